// File: rtl/conv_layer_stream_pkg.sv
// Shared state encoding, geometry helpers and saturation bounds for the
// streaming convolution layer.
package conv_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MAC  = 3'd1;
  localparam logic [2:0] FIN  = 3'd2;
  localparam logic [2:0] OUT  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter/port width that never collapses to zero bits for single-element dimensions.
  function automatic int cwidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int out_dim(input int n, input int f, input int s);
    return (n - f) / s + 1;
  endfunction

  function automatic int n_taps(input int d, input int f);
    return d * f * f;
  endfunction

  function automatic longint sat_hi(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/conv_layer_stream_if.sv
// Result stream of the convolution layer: one output pixel (all channels)
// per valid/ready handshake, tagged with its output row and column.
interface conv_layer_stream_if #(
  parameter int K          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ROW_W      = 1,
  parameter int COL_W      = 1
);
  logic                    out_valid;
  logic                    out_ready;
  logic [K*DATA_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;

  modport master (output out_valid, out_data, out_row, out_col, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, output out_ready);
endinterface

// File: rtl/conv_layer_stream_mac.sv
// One output channel: serial multiply-accumulate, then bias, round-half-up,
// optional ReLU and saturation into the registered result word.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         finish,
  input  logic                         relu,
  input  logic signed [DATA_WIDTH-1:0] pixel,
  input  logic signed [DATA_WIDTH-1:0] coeff,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_hi(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_lo(DATA_WIDTH));
  // Half an LSB of the output scale; zero when there are no fractional bits.
  localparam logic signed [ACC_WIDTH-1:0] ROUND =
    ACC_WIDTH'(longint'(FRAC_BITS > 0) << (FRAC_BITS > 0 ? FRAC_BITS - 1 : 0));

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    biased;
  logic signed [ACC_WIDTH-1:0]    rounded;
  logic signed [ACC_WIDTH-1:0]    clipped;

  always_comb begin
    product = pixel * coeff;
    biased  = acc + (ACC_WIDTH'(bias) <<< FRAC_BITS);
    rounded = (biased + ROUND) >>> FRAC_BITS;
    clipped = (relu && rounded < 0) ? '0 : rounded;
    if (clipped > SAT_HI) begin
      clipped = SAT_HI;
    end else if (clipped < SAT_LO) begin
      clipped = SAT_LO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (enable) begin
        acc <= acc + ACC_WIDTH'(product);
      end
      if (finish) begin
        result <= clipped[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Strided multi-filter 2-D convolution layer: walks output pixels in raster
// order, feeding one tap per cycle to K parallel channel units.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8,
  parameter int D          = 1,
  parameter int H          = 48,
  parameter int W          = 48,
  parameter int F          = 3,
  parameter int S          = 1,
  parameter int K          = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             relu_en,
  input  logic [D*H*W*DATA_WIDTH-1:0]      image,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]    filter,
  input  logic [K*DATA_WIDTH-1:0]          bias,
  conv_layer_stream_if.master              stream,
  output logic                             busy,
  output logic                             done
);

  localparam int HO     = out_dim(H, F, S);
  localparam int WO     = out_dim(W, F, S);
  localparam int N_TAPS = n_taps(D, F);
  localparam int RW     = cwidth(HO);
  localparam int CW     = cwidth(WO);
  localparam int DW     = cwidth(D);
  localparam int FW     = cwidth(F);

  logic [2:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] tap_d;
  logic [FW-1:0] tap_y;
  logic [FW-1:0] tap_x;
  logic          relu_q;
  logic          last_tap;
  logic          last_pix;
  logic          handshake;
  logic          acc_clear;
  logic          acc_en;
  logic          acc_fin;
  int            tap_idx;
  int            pix_idx;
  logic signed [DATA_WIDTH-1:0] ch_result [K];

  // Control decode plus the operand addresses for the current tap.
  always_comb begin
    last_tap  = (int'(tap_d) == D - 1) && (int'(tap_y) == F - 1) && (int'(tap_x) == F - 1);
    last_pix  = (int'(row) == HO - 1) && (int'(col) == WO - 1);
    handshake = (state == OUT) && stream.out_ready;
    acc_clear = ((state == IDLE) && start) || (handshake && !last_pix);
    acc_en    = (state == MAC);
    acc_fin   = (state == FIN);
    tap_idx   = (int'(tap_d) * F + int'(tap_y)) * F + int'(tap_x);
    pix_idx   = (int'(tap_d) * H + int'(row) * S + int'(tap_y)) * W + int'(col) * S + int'(tap_x);
  end

  for (genvar k = 0; k < K; k++) begin : g_ch
    conv_mac_unit #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clear (acc_clear),
      .enable(acc_en),
      .finish(acc_fin),
      .relu  (relu_q),
      .pixel (image[pix_idx*DATA_WIDTH +: DATA_WIDTH]),
      .coeff (filter[(k*N_TAPS + tap_idx)*DATA_WIDTH +: DATA_WIDTH]),
      .bias  (bias[k*DATA_WIDTH +: DATA_WIDTH]),
      .result(ch_result[k])
    );
  end

  always_comb begin
    stream.out_data = '0;
    for (int k = 0; k < K; k++) begin
      stream.out_data[k*DATA_WIDTH +: DATA_WIDTH] = ch_result[k];
    end
  end

  assign stream.out_valid = (state == OUT);
  assign stream.out_row   = row;
  assign stream.out_col   = col;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

  // Layer sequencing: taps advance x fastest, then y, then depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      tap_d  <= '0;
      tap_y  <= '0;
      tap_x  <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= MAC;
          row    <= '0;
          col    <= '0;
          tap_d  <= '0;
          tap_y  <= '0;
          tap_x  <= '0;
          relu_q <= relu_en;
        end
        MAC: begin
          if (last_tap) begin
            tap_d <= '0;
            tap_y <= '0;
            tap_x <= '0;
            state <= FIN;
          end else if (int'(tap_x) == F - 1) begin
            tap_x <= '0;
            if (int'(tap_y) == F - 1) begin
              tap_y <= '0;
              tap_d <= tap_d + 1'b1;
            end else begin
              tap_y <= tap_y + 1'b1;
            end
          end else begin
            tap_x <= tap_x + 1'b1;
          end
        end
        FIN: state <= OUT;
        OUT: if (stream.out_ready) begin
          if (last_pix) begin
            state <= DONE;
          end else begin
            state <= MAC;
            if (int'(col) == WO - 1) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench for conv_layer_stream: three layer configurations on one clock,
// each with a scoreboard queue of expected pixels checked at every handshake.
module tb_conv_layer_stream;

  typedef struct packed {
    logic [31:0] data;
    logic        row;
    logic        col;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic startA = 1'b0, startB = 1'b0, startC = 1'b0;
  logic reluA  = 1'b0, reluB  = 1'b0, reluC  = 1'b0;
  logic readyA = 1'b1, readyB = 1'b1, readyC = 1'b1;
  logic busyA, doneA, busyB, doneB, busyC, doneC;

  logic [16*16-1:0] imgA;
  logic [9*16-1:0]  filtA;
  logic [15:0]      biasA;
  logic [25*16-1:0] imgB;
  logic [18*16-1:0] filtB;
  logic [31:0]      biasB;
  logic [15:0]      imgC, filtC, biasC;

  exp_t qA[$], qB[$], qC[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   hsCount[3];
  logic lastHs[3];

  always #5 clk = ~clk;

  conv_layer_stream_if #(.K(1), .DATA_WIDTH(16), .ROW_W(1), .COL_W(1)) sA ();
  conv_layer_stream_if #(.K(2), .DATA_WIDTH(16), .ROW_W(1), .COL_W(1)) sB ();
  conv_layer_stream_if #(.K(1), .DATA_WIDTH(16), .ROW_W(1), .COL_W(1)) sC ();

  assign sA.out_ready = readyA;
  assign sB.out_ready = readyB;
  assign sC.out_ready = readyC;

  conv_layer_stream #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(0), .D(1), .H(4), .W(4),
                      .F(3), .S(1), .K(1)) dutA (
    .clk(clk), .reset(reset), .start(startA), .relu_en(reluA), .image(imgA),
    .filter(filtA), .bias(biasA), .stream(sA), .busy(busyA), .done(doneA));

  conv_layer_stream #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(0), .D(1), .H(5), .W(5),
                      .F(3), .S(2), .K(2)) dutB (
    .clk(clk), .reset(reset), .start(startB), .relu_en(reluB), .image(imgB),
    .filter(filtB), .bias(biasB), .stream(sB), .busy(busyB), .done(doneB));

  conv_layer_stream #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8), .D(1), .H(1), .W(1),
                      .F(1), .S(1), .K(1)) dutC (
    .clk(clk), .reset(reset), .start(startC), .relu_en(reluC), .image(imgC),
    .filter(filtC), .bias(biasC), .stream(sC), .busy(busyC), .done(doneC));

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboards: each handshake pops the oldest expected pixel of its instance.
  always @(negedge clk) begin
    exp_t e;
    lastHs[0] = sA.out_valid && sA.out_ready;
    if (lastHs[0]) begin
      hsCount[0]++;
      checkOutput("A pixel expected", 64'(qA.size() != 0), 64'd1);
      if (qA.size() != 0) begin
        e = qA.pop_front();
        checkOutput("A data", 64'(sA.out_data), 64'(e.data[15:0]));
        checkOutput("A row", 64'(sA.out_row), 64'(e.row));
        checkOutput("A col", 64'(sA.out_col), 64'(e.col));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    lastHs[1] = sB.out_valid && sB.out_ready;
    if (lastHs[1]) begin
      hsCount[1]++;
      checkOutput("B pixel expected", 64'(qB.size() != 0), 64'd1);
      if (qB.size() != 0) begin
        e = qB.pop_front();
        checkOutput("B data", 64'(sB.out_data), 64'(e.data));
        checkOutput("B row", 64'(sB.out_row), 64'(e.row));
        checkOutput("B col", 64'(sB.out_col), 64'(e.col));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    lastHs[2] = sC.out_valid && sC.out_ready;
    if (lastHs[2]) begin
      hsCount[2]++;
      checkOutput("C pixel expected", 64'(qC.size() != 0), 64'd1);
      if (qC.size() != 0) begin
        e = qC.pop_front();
        checkOutput("C data", 64'(sC.out_data), 64'(e.data[15:0]));
      end
    end
  end

  function automatic logic validOf(input int id);
    case (id)
      0:       return sA.out_valid;
      1:       return sB.out_valid;
      default: return sC.out_valid;
    endcase
  endfunction

  function automatic logic busyOf(input int id);
    case (id)
      0:       return busyA;
      1:       return busyB;
      default: return busyC;
    endcase
  endfunction

  function automatic logic doneOf(input int id);
    case (id)
      0:       return doneA;
      1:       return doneB;
      default: return doneC;
    endcase
  endfunction

  function automatic int qSize(input int id);
    case (id)
      0:       return qA.size();
      1:       return qB.size();
      default: return qC.size();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id);
    case (id)
      0:       startA = 1'b1;
      1:       startB = 1'b1;
      default: startC = 1'b1;
    endcase
    tick();
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
  endtask

  task automatic waitValid(input int id, input int expLat);
    int e;
    e = 0;
    while (e < 200 && !validOf(id)) begin
      tick();
      e++;
    end
    checkOutput($sformatf("latency of instance %0d", id), 64'(e), 64'(expLat));
  endtask

  task automatic waitDone(input int id, input int expHs, input string tag);
    int n;
    n = 0;
    while (n < 400 && !doneOf(id)) begin
      tick();
      n++;
    end
    checkOutput({tag, " done seen"}, 64'(doneOf(id)), 64'd1);
    checkOutput({tag, " done right after last handshake"}, 64'(lastHs[id]), 64'd1);
    checkOutput({tag, " busy during done"}, 64'(busyOf(id)), 64'd1);
    checkOutput({tag, " pixel count"}, 64'(hsCount[id]), 64'(expHs));
    checkOutput({tag, " queue drained"}, 64'(qSize(id)), 64'd0);
    tick();
    checkOutput({tag, " done single cycle"}, 64'(doneOf(id)), 64'd0);
    checkOutput({tag, " busy cleared"}, 64'(busyOf(id)), 64'd0);
  endtask

  task automatic pushA();
    qA.push_back('{data: 32'd9, row: 1'b0, col: 1'b0});
    qA.push_back('{data: 32'd9, row: 1'b0, col: 1'b1});
    qA.push_back('{data: 32'd9, row: 1'b1, col: 1'b0});
    qA.push_back('{data: 32'd9, row: 1'b1, col: 1'b1});
  endtask

  task automatic runC(input string tag, input logic [15:0] img, input logic [15:0] flt,
                      input logic [15:0] b, input logic relu, input logic [15:0] res);
    imgC  = img;
    filtC = flt;
    biasC = b;
    reluC = relu;
    qC.push_back('{data: 32'(res), row: 1'b0, col: 1'b0});
    hsCount[2] = 0;
    applyStimulus(2);
    waitValid(2, 2);
    waitDone(2, 1, tag);
  endtask

  initial begin
    int n;
    imgA  = {16{16'h0001}};
    filtA = {9{16'h0001}};
    biasA = 16'h0000;
    for (int i = 0; i < 25; i++) imgB[i*16 +: 16] = 16'(i);
    filtB = '0;
    for (int i = 0; i < 9; i++) filtB[i*16 +: 16] = 16'd1;
    filtB[13*16 +: 16] = 16'd1;
    biasB = {16'd100, 16'd0};
    imgC  = '0;
    filtC = '0;
    biasC = '0;
    hsCount = '{0, 0, 0};
    lastHs  = '{1'b0, 1'b0, 1'b0};

    tick();
    tick();
    checkOutput("reset out_valid", 64'(sA.out_valid), 64'd0);
    checkOutput("reset busy", 64'(busyA), 64'd0);
    checkOutput("reset done", 64'(doneA), 64'd0);
    checkOutput("reset out_data", 64'(sA.out_data), 64'd0);
    checkOutput("reset out_row", 64'(sA.out_row), 64'd0);
    checkOutput("reset out_col", 64'(sA.out_col), 64'd0);
    checkOutput("reset B out_data", 64'(sB.out_data), 64'd0);
    reset = 1'b1;
    tick();

    $display("[TB] basic 4x4 layer, all ones");
    hsCount[0] = 0;
    pushA();
    applyStimulus(0);
    waitValid(0, 10);
    waitDone(0, 4, "basic");

    $display("[TB] backpressure on second pixel");
    hsCount[0] = 0;
    pushA();
    applyStimulus(0);
    n = 0;
    while (n < 100 && !(sA.out_valid && hsCount[0] == 1)) begin
      tick();
      n++;
    end
    readyA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall valid", 64'(sA.out_valid), 64'd1);
      checkOutput("stall data", 64'(sA.out_data), 64'd9);
      checkOutput("stall row", 64'(sA.out_row), 64'd0);
      checkOutput("stall col", 64'(sA.out_col), 64'd1);
    end
    readyA = 1'b1;
    waitDone(0, 4, "stall");

    $display("[TB] stride 2, two filters with bias");
    qB.push_back('{data: {16'd106, 16'd54},  row: 1'b0, col: 1'b0});
    qB.push_back('{data: {16'd108, 16'd72},  row: 1'b0, col: 1'b1});
    qB.push_back('{data: {16'd116, 16'd144}, row: 1'b1, col: 1'b0});
    qB.push_back('{data: {16'd118, 16'd162}, row: 1'b1, col: 1'b1});
    hsCount[1] = 0;
    applyStimulus(1);
    waitValid(1, 10);
    waitDone(1, 4, "stride");

    $display("[TB] fixed-point rounding, saturation and ReLU");
    runC("q 1.5x1.0",       16'h0180, 16'h0100, 16'h0000, 1'b0, 16'h0180);
    runC("q sat high",      16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF);
    runC("q sat low",       16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h8000);
    runC("q relu neg",      16'h8000, 16'h7FFF, 16'h0000, 1'b1, 16'h0000);
    runC("q half up pos",   16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001);
    runC("q half up neg",   16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'h0000);
    runC("q neg bias",      16'h0000, 16'h0100, 16'hFFFE, 1'b0, 16'hFFFE);
    runC("q relu pos bias", 16'h0100, 16'h0100, 16'h0001, 1'b1, 16'h0101);

    $display("[TB] reset during second pixel");
    hsCount[0] = 0;
    pushA();
    applyStimulus(0);
    n = 0;
    while (n < 100 && hsCount[0] == 0) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("abort out_valid", 64'(sA.out_valid), 64'd0);
    checkOutput("abort busy", 64'(busyA), 64'd0);
    checkOutput("abort done", 64'(doneA), 64'd0);
    checkOutput("abort out_data", 64'(sA.out_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    qA.delete();
    tick();
    hsCount[0] = 0;
    pushA();
    applyStimulus(0);
    waitValid(0, 10);
    waitDone(0, 4, "after abort");

    $display("[TB] start held high through a layer");
    hsCount[0] = 0;
    pushA();
    startA = 1'b1;
    tick();
    checkOutput("held start busy", 64'(busyA), 64'd1);
    waitDone(0, 4, "held start");
    hsCount[0] = 0;
    pushA();
    tick();
    checkOutput("restart after idle", 64'(busyA), 64'd1);
    startA = 1'b0;
    waitDone(0, 4, "restart");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
